// File: rtl/fast_ring_fetch_pkg.sv
// fast_pkg: FAST-16 ring geometry and fetch FSM state type shared by the ring-fetch block
package fast_pkg;

    localparam int RING_LEN = 16;

    // Bresenham radius-3 ring, clockwise from north
    localparam logic signed [2:0] RING_DX [RING_LEN] = '{
         3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
         3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
    };

    localparam logic signed [2:0] RING_DY [RING_LEN] = '{
        -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
         3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
    };

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/fast_ring_fetch_if.sv
// fast_ring_fetch_if: request, SRAM read port and result bundle of the FAST-16 ring fetch
interface fast_ring_fetch_if import fast_pkg::*; #(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480
);

    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);

    logic                            start;
    logic [XW-1:0]                   cx;
    logic [YW-1:0]                   cy;
    logic signed [XW:0]              x_addr;
    logic signed [YW:0]              y_addr;
    logic                            ren;
    logic [PIXEL_DEPTH-1:0]          rdat;
    logic                            busy;
    logic                            done;
    logic                            border;
    logic [PIXEL_DEPTH-1:0]          center_px;
    logic [RING_LEN*PIXEL_DEPTH-1:0] ring_px;

    // the fetch block
    modport master (
        input  start, cx, cy, rdat,
        output x_addr, y_addr, ren, busy, done, border, center_px, ring_px
    );

    // requester plus image SRAM
    modport slave (
        output start, cx, cy, rdat,
        input  x_addr, y_addr, ren, busy, done, border, center_px, ring_px
    );

endinterface

// File: rtl/fast_ring_fetch.sv
// fast_ring_fetch: reads centre + 16 ring pixels from the image SRAM, zeroing off-image points (optional FAST_FETCH_SKIP_BORDER_EN)
module fast_ring_fetch import fast_pkg::*; #(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480
) (
    input logic               clk,
    input logic               n_rst,
    fast_ring_fetch_if.master bus
);

    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int CW = ((XW > YW) ? XW : YW) + 2;
    localparam int P  = PIXEL_DEPTH;

`ifdef FAST_FETCH_SKIP_BORDER_EN
    localparam bit SKIP_BORDER = 1'b1;
`else
    localparam bit SKIP_BORDER = 1'b0;
`endif

    fetch_state_t         state_q, state_d;
    logic [4:0]           k_q, k_d;
    logic [XW-1:0]        cx_q;
    logic [YW-1:0]        cy_q;
    logic                 border_q, border_d;
    logic                 pend_q, vld_q;
    logic [4:0]           idx_q;
    logic [P-1:0]         center_q;
    logic [RING_LEN*P-1:0] ring_q;
    logic signed [2:0]    dx, dy;
    logic signed [CW-1:0] px, py;
    logic                 inb, start_ok, last_issue;

    // point address for the current fetch index and its in-image test
    always_comb begin
        dx         = (k_q == 5'd0) ? 3'sd0 : RING_DX[4'(k_q - 5'd1)];
        dy         = (k_q == 5'd0) ? 3'sd0 : RING_DY[4'(k_q - 5'd1)];
        px         = $signed(CW'(cx_q)) + $signed({{(CW-3){dx[2]}}, dx});
        py         = $signed(CW'(cy_q)) + $signed({{(CW-3){dy[2]}}, dy});
        inb        = (state_q == ISSUE) && !px[CW-1] && !py[CW-1] &&
                     (px < CW'(X_MAX)) && (py < CW'(Y_MAX));
        border_d   = (int'(bus.cx) < 3) || (int'(bus.cy) < 3) ||
                     (int'(bus.cx) > X_MAX - 4) || (int'(bus.cy) > Y_MAX - 4);
        start_ok   = (state_q == IDLE) && bus.start;
        last_issue = (k_q == 5'd16);
        k_d        = ((state_q == ISSUE) && !last_issue) ? k_q + 5'd1 : 5'd0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; border centres may bypass the reads entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? ((SKIP_BORDER && border_d) ? DONE : ISSUE) : IDLE;
            ISSUE:   state_d = last_issue ? DRAIN : ISSUE;
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: read port is driven only for in-image points
    always_comb begin
        bus.ren       = inb;
        bus.x_addr    = inb ? px[XW:0] : '0;
        bus.y_addr    = inb ? py[YW:0] : '0;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.border    = border_q;
        bus.center_px = center_q;
        bus.ring_px   = ring_q;
    end

    // request latch, read-flag pipeline and result capture one cycle behind each issue
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            border_q <= 1'b0;
            pend_q   <= 1'b0;
            vld_q    <= 1'b0;
            idx_q    <= '0;
            center_q <= '0;
            ring_q   <= '0;
        end else begin
            k_q    <= k_d;
            pend_q <= (state_q == ISSUE);
            vld_q  <= inb;
            idx_q  <= k_q;
            if (start_ok) begin
                cx_q     <= bus.cx;
                cy_q     <= bus.cy;
                border_q <= border_d;
                center_q <= '0;
                ring_q   <= '0;
            end else if (pend_q) begin
                if (idx_q == 5'd0) center_q <= vld_q ? bus.rdat : '0;
                else ring_q[(int'(idx_q) - 1) * P +: P] <= vld_q ? bus.rdat : '0;
            end
        end
    end

endmodule

// File: doc/fast_ring_fetch.md
# fast_ring_fetch

Fetches the 17-pixel FAST-16 neighbourhood (centre plus the 16-point radius-3 Bresenham ring) for one candidate corner from the synchronous 2D image SRAM (`sram_image`), and presents it as a registered parallel bundle. It sits directly downstream of the image SRAM, drives the SRAM's read-side address and `ren` ports, and feeds the corner-score stage. Ring points outside the image are not read; they are returned as 0.

## Interface
- `PIXEL_DEPTH`, 8, bits per pixel; must match the SRAM.
- `X_MAX`, 640, image width in pixels.
- `Y_MAX`, 480, image height in pixels.
- `clk`  in  1  system clock; shared with the SRAM `ramclk`.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `cx`  in  $clog2(X_MAX)  centre x, unsigned, less than X_MAX.
- `cy`  in  $clog2(Y_MAX)  centre y, unsigned, less than Y_MAX.
- `x_addr`  out  $clog2(X_MAX)+1  signed SRAM x address.
- `y_addr`  out  $clog2(Y_MAX)+1  signed SRAM y address.
- `ren`  out  1  SRAM read enable.
- `rdat`  in  PIXEL_DEPTH  SRAM read data, valid the cycle after `ren`.
- `busy`  out  1  fetch in progress.
- `done`  out  1  one-cycle pulse when the outputs are valid.
- `border`  out  1  centre lies within 3 pixels of any image edge.
- `center_px`  out  PIXEL_DEPTH  centre pixel.
- `ring_px`  out  16*PIXEL_DEPTH  ring pixels; ring index k occupies bits [k*PIXEL_DEPTH +: PIXEL_DEPTH].

## Operation
- States:
  - IDLE: waits for `start`.
  - ISSUE: 17 cycles, fetch index k = 0..16. k = 0 is the centre; k = 1..16 is ring point k-1.
  - DRAIN: 1 cycle, captures the last read.
  - DONE: 1 cycle, then returns to IDLE.
- Ring offsets (dx, dy), ring index 0..15, clockwise from north: (0,-3) (1,-3) (2,-2) (3,-1) (3,0) (3,1) (2,2) (1,3) (0,3) (-1,3) (-2,2) (-3,1) (-3,0) (-3,-1) (-2,-2) (-1,-3).
- On `start` in IDLE:
  - `cx` and `cy` are registered.
  - `border` is computed: cx<3 or cy<3 or cx>X_MAX-4 or cy>Y_MAX-4.
- Per ISSUE cycle:
  - Compute px = cx+dx and py = cy+dy at width max($clog2(X_MAX), $clog2(Y_MAX))+2, signed. No overflow is allowed at this width.
  - The point is in bounds iff 0≤px<X_MAX and 0≤py<Y_MAX.
  - In bounds: `ren`=1, and `x_addr`/`y_addr` are driven with px/py truncated to the port width.
  - Out of bounds: `ren`=0, `x_addr`=`y_addr`=0.
  - A one-bit valid flag is pipelined alongside each issued read.
- Capture in the cycle after each ISSUE cycle:
  - Index k is written from `rdat` if its flag is 1, else with 0.
  - OOB zeroing never relies on the SRAM's own masking.
- `start` while not in IDLE is ignored.
- Reset, asynchronous and possibly mid-fetch:
  - State returns to IDLE; all outputs go to 0.
  - No partial results survive.
  - The SRAM is never written by this block.
- `center_px`, `ring_px` and `border` hold their values from DONE until the next `start` is accepted.

## Timing
- `start` high in cycle 0 → ISSUE in cycles 1–17 → DRAIN in cycle 18 → DONE in cycle 19, with `done`=1 and the outputs valid → IDLE in cycle 20.
- `busy` is 1 in cycles 1–19.
- `done` is a single cycle wide.
- Back-to-back: the earliest next `start` is accepted in cycle 20.
- Reset values of every output: `ren`, `busy`, `done`, `border` = 0; `x_addr`, `y_addr`, `center_px`, `ring_px` = 0.

## Configuration
- `FAST_FETCH_SKIP_BORDER_EN`
  - Defined: a `start` whose centre gives `border`=1 skips ISSUE and DRAIN entirely. No `ren` is issued, `center_px` and `ring_px` are cleared to 0, and the block goes straight to DONE in cycle 1. `busy` is 1 in cycle 1 only.
  - Undefined: every centre gets the full 17-read fetch, with out-of-image points read as 0; `border` is informational only.

## Structure
- Package `fast_pkg` holds:
  - the ring offset constant arrays `RING_DX` and `RING_DY` (16 entries of signed 3-bit);
  - the constant `RING_LEN`=16;
  - the state enum `fetch_state_t`.
- Single module, no sub-module; offset lookup is indexed by the fetch counter.

## Test plan
All scenarios use X_MAX=Y_MAX=8 and an image ramp with pixel(x,y) = 8y+x.

- Centre (4,4):
  - 17 `ren` pulses in cycles 1–17 and `done` in cycle 19.
  - `center_px`=36, ring[0]=12, ring[4]=39, ring[8]=60, ring[12]=33.
- Centre (0,0), macro undefined:
  - Exactly 6 `ren` pulses.
  - ring[4]=3, ring[6]=18, ring[8]=24, ring[0]=0, ring[12]=0, `border`=1.
- Centre (0,0), `FAST_FETCH_SKIP_BORDER_EN` defined:
  - No `ren`; `done` in cycle 1; `ring_px`=0.
- `start` pulsed again in cycle 5 with centre (3,3):
  - Ignored; the results equal those of the first request.
- `n_rst` asserted in cycle 10:
  - All outputs are 0 immediately and state is IDLE.
  - A new `start` after release behaves exactly as scenario 1.
- Centre (7,7) then (4,4) back-to-back, with the second `start` in cycle 20:
  - The second `done` arrives in cycle 39 with the scenario-1 values.
